// File: rtl/text_term_ctrl.sv
// Terminal-style sequencer for the character screen buffer: decodes UART bytes
// into buffer writes and cursor moves, and sweeps the screen blank on reset or FF.
module text_term_ctrl #(
  parameter int N_COL           = 175,
  parameter int N_ROW           = 65,
  parameter int N_COL_WIDTH     = 8,
  parameter int N_ROW_WIDTH     = 7,
  parameter int N_CHARS_WIDTH   = 7,
  parameter int UART_DATA_WIDTH = 8,
  parameter logic [N_CHARS_WIDTH-1:0] BLANK_CHAR = 7'h20
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       rx_wr_i,
  input  logic [UART_DATA_WIDTH-1:0] rx_data_i,
  output logic                       wr_en_o,
  output logic [N_COL_WIDTH-1:0]     col_w_o,
  output logic [N_ROW_WIDTH-1:0]     row_w_o,
  output logic [N_CHARS_WIDTH-1:0]   din_o,
  output logic [N_COL_WIDTH-1:0]     cursor_col_o,
  output logic [N_ROW_WIDTH-1:0]     cursor_row_o,
  output logic                       busy_o,
  output logic                       drop_o
);

  // state    | meaning
  // IDLE     | decode printable / control bytes at the cursor
  // ESC_COL  | next byte is the absolute cursor column (clamped)
  // ESC_ROW  | next byte is the absolute cursor row (clamped)
  // CLEAR    | blank sweep of the whole screen, incoming bytes dropped
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ESC_COL = 2'd1,
    ST_ESC_ROW = 2'd2,
    ST_CLEAR   = 2'd3
  } state_t;

  localparam logic [N_COL_WIDTH-1:0]     COL_MAX  = N_COL_WIDTH'(N_COL - 1);
  localparam logic [N_ROW_WIDTH-1:0]     ROW_MAX  = N_ROW_WIDTH'(N_ROW - 1);
  localparam logic [N_COL_WIDTH-1:0]     COL_ONE  = N_COL_WIDTH'(1);
  localparam logic [N_ROW_WIDTH-1:0]     ROW_ONE  = N_ROW_WIDTH'(1);
  localparam logic [UART_DATA_WIDTH-1:0] COL_LIM  = UART_DATA_WIDTH'(N_COL - 1);
  localparam logic [UART_DATA_WIDTH-1:0] ROW_LIM  = UART_DATA_WIDTH'(N_ROW - 1);
  localparam logic [UART_DATA_WIDTH-1:0] CH_FIRST = UART_DATA_WIDTH'(8'h20);
  localparam logic [UART_DATA_WIDTH-1:0] CH_LAST  = UART_DATA_WIDTH'(8'h7E);
  localparam logic [UART_DATA_WIDTH-1:0] CH_CR    = UART_DATA_WIDTH'(8'h0D);
  localparam logic [UART_DATA_WIDTH-1:0] CH_LF    = UART_DATA_WIDTH'(8'h0A);
  localparam logic [UART_DATA_WIDTH-1:0] CH_BS    = UART_DATA_WIDTH'(8'h08);
  localparam logic [UART_DATA_WIDTH-1:0] CH_FF    = UART_DATA_WIDTH'(8'h0C);
  localparam logic [UART_DATA_WIDTH-1:0] CH_ESC   = UART_DATA_WIDTH'(8'h1B);

  state_t                   state_q, state_d;
  logic                     rx_prev_q;
  logic [N_COL_WIDTH-1:0]   cur_col_q, cur_col_d;
  logic [N_ROW_WIDTH-1:0]   cur_row_q, cur_row_d;
  logic [N_COL_WIDTH-1:0]   sw_col_q, sw_col_d;
  logic [N_ROW_WIDTH-1:0]   sw_row_q, sw_row_d;
  logic                     sw_done_q, sw_done_d;
  logic                     wr_en_q, wr_en_d;
  logic [N_COL_WIDTH-1:0]   col_w_q, col_w_d;
  logic [N_ROW_WIDTH-1:0]   row_w_q, row_w_d;
  logic [N_CHARS_WIDTH-1:0] din_q, din_d;
  logic                     busy_q, busy_d;
  logic                     drop_q, drop_d;
  logic                     evt;
  logic [N_ROW_WIDTH-1:0]   row_inc;

  assign evt     = rx_wr_i && !rx_prev_q;
  assign row_inc = (cur_row_q == ROW_MAX) ? '0 : cur_row_q + ROW_ONE;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_CLEAR;
      rx_prev_q <= 1'b0;
      cur_col_q <= '0;
      cur_row_q <= '0;
      sw_col_q  <= '0;
      sw_row_q  <= '0;
      sw_done_q <= 1'b0;
      wr_en_q   <= 1'b0;
      col_w_q   <= '0;
      row_w_q   <= '0;
      din_q     <= BLANK_CHAR;
      busy_q    <= 1'b1;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_prev_q <= rx_wr_i;
      cur_col_q <= cur_col_d;
      cur_row_q <= cur_row_d;
      sw_col_q  <= sw_col_d;
      sw_row_q  <= sw_row_d;
      sw_done_q <= sw_done_d;
      wr_en_q   <= wr_en_d;
      col_w_q   <= col_w_d;
      row_w_q   <= row_w_d;
      din_q     <= din_d;
      busy_q    <= busy_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_col_d = cur_col_q;
    cur_row_d = cur_row_q;
    sw_col_d  = sw_col_q;
    sw_row_d  = sw_row_q;
    sw_done_d = sw_done_q;
    wr_en_d   = 1'b0;
    col_w_d   = col_w_q;
    row_w_d   = row_w_q;
    din_d     = din_q;
    busy_d    = busy_q;
    drop_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (evt) begin
          if (rx_data_i >= CH_FIRST && rx_data_i <= CH_LAST) begin
            wr_en_d = 1'b1;
            col_w_d = cur_col_q;
            row_w_d = cur_row_q;
            din_d   = rx_data_i[N_CHARS_WIDTH-1:0];
            if (cur_col_q == COL_MAX) begin
              cur_col_d = '0;
              cur_row_d = row_inc;
            end else begin
              cur_col_d = cur_col_q + COL_ONE;
            end
          end else if (rx_data_i == CH_CR) begin
            cur_col_d = '0;
          end else if (rx_data_i == CH_LF) begin
            cur_row_d = row_inc;
          end else if (rx_data_i == CH_BS) begin
            // backspace never wraps to the previous row
            if (cur_col_q != '0) begin
              cur_col_d = cur_col_q - COL_ONE;
              wr_en_d   = 1'b1;
              col_w_d   = cur_col_q - COL_ONE;
              row_w_d   = cur_row_q;
              din_d     = BLANK_CHAR;
            end
          end else if (rx_data_i == CH_FF) begin
            state_d   = ST_CLEAR;
            sw_col_d  = '0;
            sw_row_d  = '0;
            sw_done_d = 1'b0;
            busy_d    = 1'b1;
          end else if (rx_data_i == CH_ESC) begin
            state_d = ST_ESC_COL;
          end
        end
      end

      ST_ESC_COL: begin
        if (evt) begin
          cur_col_d = (rx_data_i > COL_LIM) ? COL_MAX : N_COL_WIDTH'(rx_data_i);
          state_d   = ST_ESC_ROW;
        end
      end

      ST_ESC_ROW: begin
        if (evt) begin
          cur_row_d = (rx_data_i > ROW_LIM) ? ROW_MAX : N_ROW_WIDTH'(rx_data_i);
          state_d   = ST_IDLE;
        end
      end

      ST_CLEAR: begin
        drop_d = evt;
        // one extra cycle after the last write so busy falls together with the IDLE return
        if (sw_done_q) begin
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
          cur_col_d = '0;
          cur_row_d = '0;
        end else begin
          wr_en_d = 1'b1;
          col_w_d = sw_col_q;
          row_w_d = sw_row_q;
          din_d   = BLANK_CHAR;
          if (sw_col_q == COL_MAX) begin
            sw_col_d = '0;
            if (sw_row_q == ROW_MAX) begin
              sw_row_d  = '0;
              sw_done_d = 1'b1;
            end else begin
              sw_row_d = sw_row_q + ROW_ONE;
            end
          end else begin
            sw_col_d = sw_col_q + COL_ONE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_en_o      = wr_en_q;
  assign col_w_o      = col_w_q;
  assign row_w_o      = row_w_q;
  assign din_o        = din_q;
  assign cursor_col_o = cur_col_q;
  assign cursor_row_o = cur_row_q;
  assign busy_o       = busy_q;
  assign drop_o       = drop_q;

endmodule

// File: tb/tb_text_term_ctrl.sv
// Bench for text_term_ctrl: directed and random byte streams against a screen/cursor
// reference model, plus full clear sweeps, dropped bytes and mid-sweep reset.
module tb_text_term_ctrl;

  localparam int NC = 175;
  localparam int NR = 65;
  localparam int NCELL = NC * NR;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       rx_wr_i;
  logic [7:0] rx_data_i;
  logic       wr_en_o;
  logic [7:0] col_w_o;
  logic [6:0] row_w_o;
  logic [6:0] din_o;
  logic [7:0] cursor_col_o;
  logic [6:0] cursor_row_o;
  logic       busy_o;
  logic       drop_o;

  int checks = 0;
  int errors = 0;
  int m_col, m_row, m_esc;

  text_term_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_wr_i(rx_wr_i), .rx_data_i(rx_data_i),
    .wr_en_o(wr_en_o), .col_w_o(col_w_o), .row_w_o(row_w_o), .din_o(din_o),
    .cursor_col_o(cursor_col_o), .cursor_row_o(cursor_row_o),
    .busy_o(busy_o), .drop_o(drop_o)
  );

  always #4 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference model: cursor as a linear cell index, escape as a pending-argument count.
  task automatic model_byte(input logic [7:0] b, output bit we, output int wc, output int wrow,
                            output int wd);
    int lin;
    we = 0; wc = 0; wrow = 0; wd = 0;
    if (m_esc == 1) begin
      m_col = (int'(b) > NC - 1) ? NC - 1 : int'(b);
      m_esc = 2;
    end else if (m_esc == 2) begin
      m_row = (int'(b) > NR - 1) ? NR - 1 : int'(b);
      m_esc = 0;
    end else if (b >= 8'h20 && b <= 8'h7E) begin
      we = 1; wc = m_col; wrow = m_row; wd = int'(b);
      lin = (m_row * NC + m_col + 1) % NCELL;
      m_col = lin % NC;
      m_row = lin / NC;
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0A) begin
      m_row = (m_row + 1) % NR;
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col = m_col - 1;
        we = 1; wc = m_col; wrow = m_row; wd = 32;
      end
    end else if (b == 8'h1B) begin
      m_esc = 1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int width);
    bit we;
    int wc, wrow, wd;
    model_byte(b, we, wc, wrow, wd);
    rx_data_i = b;
    rx_wr_i = 1'b1;
    tick();
    chk($sformatf("wr_en b=%02h", b), 32'(wr_en_o), 32'(we));
    if (we) begin
      chk($sformatf("col_w b=%02h", b), 32'(col_w_o), wc);
      chk($sformatf("row_w b=%02h", b), 32'(row_w_o), wrow);
      chk($sformatf("din b=%02h", b), 32'(din_o), wd);
    end
    chk($sformatf("cur_col b=%02h", b), 32'(cursor_col_o), m_col);
    chk($sformatf("cur_row b=%02h", b), 32'(cursor_row_o), m_row);
    for (int i = 1; i < width; i++) begin
      tick();
      chk("held_no_write", 32'(wr_en_o), 0);
    end
    rx_wr_i = 1'b0;
    tick();
    chk("release_no_write", 32'(wr_en_o), 0);
  endtask

  // Follows a sweep that must start writing at the next edge; optionally injects a
  // byte after inject_at writes, or asserts reset after abort_at writes.
  task automatic run_sweep(input string tag, input int inject_at, input int abort_at);
    int k, bad, drops;
    logic [7:0] ec;
    logic [6:0] er;
    k = 0; bad = 0; drops = 0;
    tick();
    chk({tag, "_start"}, 32'(wr_en_o), 1);
    while (wr_en_o === 1'b1 && k < NCELL + 100) begin
      ec = 8'(k % NC);
      er = 7'(k / NC);
      if (col_w_o !== ec || row_w_o !== er || din_o !== 7'h20 || busy_o !== 1'b1) bad++;
      if (drop_o === 1'b1) drops++;
      k++;
      if (k == abort_at) begin
        chk({tag, "_abort_pos"}, bad, 0);
        rst_i = 1'b1;
        return;
      end
      if (k == inject_at) begin
        rx_data_i = 8'h51;
        rx_wr_i = 1'b1;
      end
      if (k == inject_at + 5) rx_wr_i = 1'b0;
      tick();
    end
    if (drop_o === 1'b1) drops++;
    chk({tag, "_count"}, k, NCELL);
    chk({tag, "_pos"}, bad, 0);
    chk({tag, "_busy_end"}, 32'(busy_o), 0);
    chk({tag, "_drops"}, drops, (inject_at > 0) ? 1 : 0);
    m_col = 0; m_row = 0; m_esc = 0;
    chk({tag, "_cur_col"}, 32'(cursor_col_o), m_col);
    chk({tag, "_cur_row"}, 32'(cursor_row_o), m_row);
  endtask

  initial begin
    logic [7:0] b;
    int r;
    m_col = 0; m_row = 0; m_esc = 0;
    rst_i = 1'b1;
    rx_wr_i = 1'b0;
    rx_data_i = 8'h00;
    tick(); tick(); tick();
    chk("rst_wr_en", 32'(wr_en_o), 0);
    chk("rst_col_w", 32'(col_w_o), 0);
    chk("rst_row_w", 32'(row_w_o), 0);
    chk("rst_din", 32'(din_o), 32'h20);
    chk("rst_drop", 32'(drop_o), 0);
    chk("rst_busy", 32'(busy_o), 1);
    chk("rst_cur_col", 32'(cursor_col_o), 0);
    chk("rst_cur_row", 32'(cursor_row_o), 0);
    rst_i = 1'b0;
    run_sweep("por", -1, -1);

    send_byte(8'h41, 1);
    send_byte(8'h42, 5);
    send_byte(8'h1B, 1); send_byte(8'd174, 2); send_byte(8'd64, 1);
    send_byte(8'h5A, 1);
    send_byte(8'h1B, 1); send_byte(8'd200, 1); send_byte(8'd100, 3);
    send_byte(8'h08, 1);
    send_byte(8'h0D, 1);
    send_byte(8'h08, 1);
    send_byte(8'h0A, 1);

    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3, 4: b = 8'($urandom_range(32, 126));
        5: b = 8'h0D;
        6: b = 8'h0A;
        7: b = 8'h08;
        8: b = 8'h1B;
        default: b = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(1, 7)) : 8'($urandom_range(127, 255));
      endcase
      send_byte(b, $urandom_range(1, 3));
    end
    while (m_esc != 0) send_byte(8'($urandom_range(0, 255)), 1);

    rx_data_i = 8'h0C;
    rx_wr_i = 1'b1;
    tick();
    chk("ff_no_write", 32'(wr_en_o), 0);
    chk("ff_busy", 32'(busy_o), 1);
    rx_wr_i = 1'b0;
    run_sweep("ff", 100, -1);
    send_byte(8'h43, 1);

    rx_data_i = 8'h0C;
    rx_wr_i = 1'b1;
    tick();
    rx_wr_i = 1'b0;
    run_sweep("abort", -1, 5000);
    tick();
    chk("abort_rst_wr_en", 32'(wr_en_o), 0);
    chk("abort_rst_busy", 32'(busy_o), 1);
    chk("abort_rst_col_w", 32'(col_w_o), 0);
    tick(); tick();
    chk("abort_rst_hold", 32'(wr_en_o), 0);
    rst_i = 1'b0;
    run_sweep("rerun", -1, -1);
    send_byte(8'h44, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
